// File: rtl/simple_spi_slave_pkg.sv
`default_nettype none
// simple_spi_slave_pkg: register map, bit indices and engine state encoding
// shared by the SPI responder and its FIFO.
package simple_spi_slave_pkg;

  localparam logic [1:0] ADR_SPCR = 2'd0;
  localparam logic [1:0] ADR_SPSR = 2'd1;
  localparam logic [1:0] ADR_SPDR = 2'd2;
  localparam logic [1:0] ADR_RSVD = 2'd3;

  localparam int SPCR_SPIE = 7;
  localparam int SPCR_SPE  = 6;
  localparam int SPCR_CPOL = 3;
  localparam int SPCR_CPHA = 2;

  localparam int SPSR_SPIF = 7;
  localparam int SPSR_WCOL = 6;
  localparam int SPSR_UNDR = 5;
  localparam int SPSR_ROVR = 4;

  localparam int DEFAULT_FIFO_DEPTH = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/simple_spi_slave_if.sv
`default_nettype none
// simple_spi_slave_if: Wishbone register bus plus SPI pins of the responder.
interface simple_spi_slave_if;
  logic [1:0] adr_i;
  logic [7:0] dat_i;
  logic       we_i;
  logic       stb_i;
  logic       cyc_i;
  logic       ack_o;
  logic [7:0] dat_o;
  logic       inta_o;
  logic       sck_i;
  logic       ss_n_i;
  logic       mosi_i;
  logic       miso_o;

  modport slave (
    input  adr_i, dat_i, we_i, stb_i, cyc_i, sck_i, ss_n_i, mosi_i,
    output ack_o, dat_o, inta_o, miso_o
  );

  modport master (
    output adr_i, dat_i, we_i, stb_i, cyc_i, sck_i, ss_n_i, mosi_i,
    input  ack_o, dat_o, inta_o, miso_o
  );
endinterface
`default_nettype wire

// File: rtl/spi_slave_fifo.sv
`default_nettype none
// spi_slave_fifo: 8-bit synchronous FIFO with flush; a push into a full FIFO
// succeeds when a pop happens in the same cycle.
module spi_slave_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count != CNT_FULL) | do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
endmodule
`default_nettype wire

// File: rtl/simple_spi_slave.sv
`default_nettype none
// simple_spi_slave: oversampled SPI responder with TX/RX FIFOs behind an
// 8-bit Wishbone register interface.
module simple_spi_slave
  import simple_spi_slave_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
  parameter int SYNC_STAGES = 2
) (
  input logic                clk_i,
  input logic                rst_i,
  simple_spi_slave_if.slave  bus
);
  logic       spie, spe, cpol, cpha;
  logic       spif, wcol, undr, rovr;
  logic       ack_q;
  logic [7:0] dat_q;
  logic [7:0] rd_data;

  // Bit order inside each stage: {mosi, ss_n, sck}
  logic [2:0] sync_q [SYNC_STAGES];
  logic       sck_s, ss_s, mosi_s, sck_d, ss_d;
  logic       lead_edge, trail_edge, sample_edge, shift_edge, ss_fall, ss_rise;

  spi_state_e state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic [7:0] tx_sr, tx_sr_nxt;
  logic [6:0] rx_sr, rx_sr_nxt;
  logic [7:0] rx_byte;
  logic       load_byte, eng_tx_pop, eng_rx_push, set_spif, set_undr;

  logic       bus_req, wr, rd, cpu_push, cpu_pop;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0] tx_head, rx_head;
  logic [3:0] w1c;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'b010;
      sck_d <= 1'b0;
      ss_d  <= 1'b1;
    end else begin
      sync_q[0] <= {bus.mosi_i, bus.ss_n_i, bus.sck_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sck_d <= sck_s;
      ss_d  <= ss_s;
    end
  end

  assign sck_s       = sync_q[SYNC_STAGES-1][0];
  assign ss_s        = sync_q[SYNC_STAGES-1][1];
  assign mosi_s      = sync_q[SYNC_STAGES-1][2];
  assign lead_edge   = cpol ? (~sck_s & sck_d) : (sck_s & ~sck_d);
  assign trail_edge  = cpol ? (sck_s & ~sck_d) : (~sck_s & sck_d);
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;
  assign ss_fall     = ~ss_s & ss_d;
  assign ss_rise     = ss_s & ~ss_d;
  assign rx_byte     = {rx_sr, mosi_s};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      tx_sr <= tx_sr_nxt;
      rx_sr <= rx_sr_nxt;
    end
  end

  // A shift edge at bit count 0 is skipped: the freshly loaded MSB is already
  // on miso (CPHA=0 trailing edge after byte end, CPHA=1 first leading edge).
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    tx_sr_nxt   = tx_sr;
    rx_sr_nxt   = rx_sr;
    load_byte   = 1'b0;
    eng_tx_pop  = 1'b0;
    eng_rx_push = 1'b0;
    set_spif    = 1'b0;
    set_undr    = 1'b0;
    if (!spe) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: if (ss_fall) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
          load_byte = 1'b1;
        end
        SHIFT: if (ss_rise) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (sample_edge) begin
          rx_sr_nxt = rx_byte[6:0];
          cnt_nxt   = cnt + 3'd1;
          if (cnt == 3'd7) begin
            eng_rx_push = 1'b1;
            set_spif    = 1'b1;
            load_byte   = 1'b1;
          end
        end else if (shift_edge && cnt != 3'd0) begin
          tx_sr_nxt = {tx_sr[6:0], 1'b0};
        end
        default: state_nxt = IDLE;
      endcase
    end
    if (load_byte) begin
      tx_sr_nxt  = tx_empty ? 8'h00 : tx_head;
      eng_tx_pop = ~tx_empty;
      set_undr   = tx_empty;
    end
  end

  assign bus_req  = bus.cyc_i & bus.stb_i & ~ack_q;
  assign wr       = bus_req & bus.we_i;
  assign rd       = bus_req & ~bus.we_i;
  assign cpu_push = wr & (bus.adr_i == ADR_SPDR);
  assign cpu_pop  = rd & (bus.adr_i == ADR_SPDR) & ~rx_empty;
  assign w1c      = (wr && bus.adr_i == ADR_SPSR) ? bus.dat_i[7:4] : 4'b0000;

  spi_slave_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push(cpu_push), .pop(eng_tx_pop),
    .flush(~spe), .din(bus.dat_i), .full(tx_full), .empty(tx_empty), .head(tx_head)
  );

  spi_slave_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push(eng_rx_push), .pop(cpu_pop),
    .flush(~spe), .din(rx_byte), .full(rx_full), .empty(rx_empty), .head(rx_head)
  );

  always_comb begin
    rd_data = 8'h00;
    case (bus.adr_i)
      ADR_SPCR: rd_data = {spie, spe, 2'b00, cpol, cpha, 2'b00};
      ADR_SPSR: rd_data = {spif, wcol, undr, rovr, tx_full, tx_empty, rx_full, rx_empty};
      ADR_SPDR: rd_data = rx_empty ? 8'h00 : rx_head;
      default:  rd_data = 8'h00;
    endcase
  end

  // Flag sets take priority over a same-cycle write-1-to-clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      {spie, spe, cpol, cpha} <= 4'b0000;
      {spif, wcol, undr, rovr} <= 4'b0000;
      ack_q <= 1'b0;
      dat_q <= 8'h00;
    end else begin
      ack_q <= bus_req;
      if (wr && bus.adr_i == ADR_SPCR)
        {spie, spe, cpol, cpha} <= {bus.dat_i[SPCR_SPIE], bus.dat_i[SPCR_SPE],
                                    bus.dat_i[SPCR_CPOL], bus.dat_i[SPCR_CPHA]};
      spif <= (spif & ~w1c[SPSR_SPIF-4]) | set_spif;
      wcol <= (wcol & ~w1c[SPSR_WCOL-4]) | (cpu_push & tx_full & ~eng_tx_pop);
      undr <= (undr & ~w1c[SPSR_UNDR-4]) | set_undr;
      rovr <= (rovr & ~w1c[SPSR_ROVR-4]) | (eng_rx_push & rx_full & ~cpu_pop);
      if (rd) dat_q <= rd_data;
    end
  end

  assign bus.ack_o  = ack_q;
  assign bus.dat_o  = dat_q;
  assign bus.inta_o = spie & spif;
  assign bus.miso_o = (state == SHIFT) && spe && tx_sr[7];
endmodule
`default_nettype wire

// File: tb/tb_simple_spi_slave.sv
`default_nettype none
// tb_simple_spi_slave: drives an SPI master and Wishbone host against the
// responder and compares every observation with a queue-based model.
module tb_simple_spi_slave;
  import simple_spi_slave_pkg::*;

  localparam int DEPTH = 4;
  localparam int H     = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  simple_spi_slave_if bus_if ();

  simple_spi_slave #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus_if)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       m_spif = 0, m_wcol = 0, m_undr = 0, m_rovr = 0;
  logic       m_spe = 0, m_spie = 0, m_cpol = 0, m_cpha = 0;
  logic [7:0] m_spcr = 8'h00;
  logic [7:0] cur_tx = 8'h00;
  logic [7:0] txb [5];
  logic [7:0] rxb [5];
  logic [7:0] scratch;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] spsr_model();
    return {m_spif, m_wcol, m_undr, m_rovr,
            tx_q.size() == DEPTH, tx_q.size() == 0,
            rx_q.size() == DEPTH, rx_q.size() == 0};
  endfunction

  task automatic m_load();
    if (tx_q.size() != 0) cur_tx = tx_q.pop_front();
    else begin
      cur_tx = 8'h00;
      m_undr = 1'b1;
    end
  endtask

  task automatic m_complete(input logic [7:0] b);
    if (rx_q.size() < DEPTH) rx_q.push_back(b);
    else m_rovr = 1'b1;
    m_spif = 1'b1;
    m_load();
  endtask

  task automatic wb_access(input logic we, input logic [1:0] adr, input logic [7:0] d,
                           output logic [7:0] q);
    logic acked;
    acked = 1'b0;
    @(posedge clk);
    #1;
    bus_if.cyc_i = 1'b1;
    bus_if.stb_i = 1'b1;
    bus_if.we_i  = we;
    bus_if.adr_i = adr;
    bus_if.dat_i = d;
    for (int i = 0; i < 8 && !acked; i++) begin
      @(posedge clk);
      #1;
      acked = bus_if.ack_o;
    end
    q = bus_if.dat_o;
    bus_if.cyc_i = 1'b0;
    bus_if.stb_i = 1'b0;
    bus_if.we_i  = 1'b0;
    chk("wb_ack", {7'b0, acked}, 8'h01);
  endtask

  task automatic wb_write(input logic [1:0] adr, input logic [7:0] d);
    logic [7:0] q;
    wb_access(1'b1, adr, d, q);
    case (adr)
      2'd0: begin
        m_spcr = d & 8'hCC;
        {m_spie, m_spe, m_cpol, m_cpha} = {d[7], d[6], d[3], d[2]};
        if (!m_spe) begin
          tx_q.delete();
          rx_q.delete();
        end
      end
      2'd1: begin
        if (d[7]) m_spif = 1'b0;
        if (d[6]) m_wcol = 1'b0;
        if (d[5]) m_undr = 1'b0;
        if (d[4]) m_rovr = 1'b0;
      end
      2'd2: if (m_spe) begin
        if (tx_q.size() < DEPTH) tx_q.push_back(d);
        else m_wcol = 1'b1;
      end
      default: ;
    endcase
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] adr);
    logic [7:0] exp;
    logic [7:0] q;
    exp = 8'h00;
    if (adr == 2'd0) exp = m_spcr;
    else if (adr == 2'd1) exp = spsr_model();
    else if (adr == 2'd2 && rx_q.size() != 0) exp = rx_q.pop_front();
    wb_access(1'b0, adr, 8'h00, q);
    chk(tag, q, exp);
  endtask

  task automatic set_mode(input logic cpol, input logic cpha, input logic spie);
    wb_write(ADR_SPCR, 8'h00);
    bus_if.sck_i = cpol;
    tick(4);
    wb_write(ADR_SPCR, {spie, 1'b1, 2'b00, cpol, cpha, 2'b00});
    wb_write(ADR_SPSR, 8'hF0);
  endtask

  task automatic spi_begin();
    bus_if.ss_n_i = 1'b0;
    if (m_spe) m_load();
    tick(H);
  endtask

  task automatic spi_end();
    bus_if.ss_n_i = 1'b1;
    tick(H);
  endtask

  task automatic spi_byte(input string tag, input logic [7:0] mo, input int nbits);
    logic [7:0] mi;
    logic [7:0] exp;
    mi  = 8'h00;
    exp = cur_tx;
    for (int i = 0; i < nbits; i++) begin
      if (!m_cpha) begin
        bus_if.mosi_i = mo[7-i];
        tick(H);
        bus_if.sck_i = ~m_cpol;
        mi = {mi[6:0], bus_if.miso_o};
        tick(H);
        bus_if.sck_i = m_cpol;
      end else begin
        tick(H);
        bus_if.sck_i  = ~m_cpol;
        bus_if.mosi_i = mo[7-i];
        tick(H);
        bus_if.sck_i = m_cpol;
        mi = {mi[6:0], bus_if.miso_o};
      end
    end
    tick(H);
    if (nbits == 8) begin
      chk(tag, mi, exp);
      m_complete(mo);
    end
  endtask

  initial begin
    bus_if.adr_i  = 2'd0;
    bus_if.dat_i  = 8'h00;
    bus_if.we_i   = 1'b0;
    bus_if.stb_i  = 1'b0;
    bus_if.cyc_i  = 1'b0;
    bus_if.sck_i  = 1'b0;
    bus_if.ss_n_i = 1'b1;
    bus_if.mosi_i = 1'b0;
    tick(3);
    chk("reset_ack",  {7'b0, bus_if.ack_o},  8'h00);
    chk("reset_dat",  bus_if.dat_o,          8'h00);
    chk("reset_inta", {7'b0, bus_if.inta_o}, 8'h00);
    chk("reset_miso", {7'b0, bus_if.miso_o}, 8'h00);
    rst = 1'b0;
    tick(2);
    rd_chk("reset_spcr", ADR_SPCR);
    rd_chk("reset_spsr", ADR_SPSR);

    // Basic mode-0 exchange with interrupt
    set_mode(1'b0, 1'b0, 1'b1);
    wb_write(ADR_SPDR, 8'hA5);
    spi_begin();
    spi_byte("m0_miso", 8'h3C, 8);
    spi_end();
    chk("m0_inta_set", {7'b0, bus_if.inta_o}, 8'h01);
    rd_chk("m0_spsr", ADR_SPSR);
    rd_chk("m0_spdr", ADR_SPDR);
    wb_write(ADR_SPSR, 8'h80);
    chk("m0_inta_clr", {7'b0, bus_if.inta_o}, {7'b0, m_spie & m_spif});
    rd_chk("m0_spsr_clr", ADR_SPSR);
    wb_write(ADR_RSVD, 8'hFF);
    rd_chk("rsvd_read", ADR_RSVD);

    // Three-byte bursts in all modes: directed pass then random pass
    for (int pass = 0; pass < 2; pass++) begin
      for (int mode = 0; mode < 4; mode++) begin
        txb[0] = 8'h01; txb[1] = 8'h02; txb[2] = 8'h03;
        rxb[0] = 8'hF0; rxb[1] = 8'h0F; rxb[2] = 8'hAA;
        if (pass == 1) begin
          for (int k = 0; k < 3; k++) begin
            txb[k] = 8'($urandom_range(0, 255));
            rxb[k] = 8'($urandom_range(0, 255));
          end
        end
        set_mode(mode[1], mode[0], 1'b0);
        for (int k = 0; k < 3; k++) wb_write(ADR_SPDR, txb[k]);
        spi_begin();
        for (int k = 0; k < 3; k++) begin
          spi_byte("burst_miso", rxb[k], 8);
          rd_chk("burst_spsr", ADR_SPSR);
          wb_write(ADR_SPSR, 8'h80);
        end
        spi_end();
        for (int k = 0; k < 3; k++) rd_chk("burst_spdr", ADR_SPDR);
        rd_chk("burst_spsr_end", ADR_SPSR);
      end
    end

    // Underrun: nothing queued for transmit
    set_mode(1'b0, 1'b0, 1'b0);
    spi_begin();
    spi_byte("undr_miso", 8'($urandom_range(0, 255)), 8);
    spi_end();
    rd_chk("undr_spsr", ADR_SPSR);

    // Overrun: five bytes received with no reads
    set_mode(1'b1, 1'b1, 1'b0);
    spi_begin();
    for (int k = 0; k < 5; k++) spi_byte("ovr_miso", 8'($urandom_range(0, 255)), 8);
    spi_end();
    rd_chk("ovr_spsr", ADR_SPSR);
    for (int k = 0; k < 5; k++) rd_chk("ovr_spdr", ADR_SPDR);

    // Write collision: fifth SPDR write lost
    set_mode(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) wb_write(ADR_SPDR, 8'($urandom_range(0, 255)));
    rd_chk("wcol_spsr", ADR_SPSR);
    spi_begin();
    for (int k = 0; k < 5; k++) spi_byte("wcol_miso", 8'($urandom_range(0, 255)), 8);
    spi_end();

    // Partial byte aborted by ss_n, then a clean byte
    set_mode(1'b0, 1'b0, 1'b0);
    wb_write(ADR_SPDR, 8'($urandom_range(0, 255)));
    wb_write(ADR_SPDR, 8'($urandom_range(0, 255)));
    spi_begin();
    spi_byte("partial", 8'($urandom_range(0, 255)), 5);
    spi_end();
    rd_chk("partial_spsr", ADR_SPSR);
    spi_begin();
    spi_byte("after_partial_miso", 8'($urandom_range(0, 255)), 8);
    spi_end();
    rd_chk("after_partial_spdr", ADR_SPDR);

    // Reset asserted in the middle of a byte
    set_mode(1'b0, 1'b0, 1'b1);
    wb_write(ADR_SPDR, 8'hFF);
    wb_write(ADR_SPDR, 8'hFF);
    rd_chk("pre_rst_spcr", ADR_SPCR);
    spi_begin();
    spi_byte("pre_rst_miso", 8'h55, 8);
    spi_byte("pre_rst_partial", 8'h55, 3);
    chk("pre_rst_inta", {7'b0, bus_if.inta_o}, 8'h01);
    chk("pre_rst_miso_hi", {7'b0, bus_if.miso_o}, 8'h01);
    chk("pre_rst_dat", bus_if.dat_o, 8'hC0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ack",  {7'b0, bus_if.ack_o},  8'h00);
    chk("mid_rst_dat",  bus_if.dat_o,          8'h00);
    chk("mid_rst_inta", {7'b0, bus_if.inta_o}, 8'h00);
    chk("mid_rst_miso", {7'b0, bus_if.miso_o}, 8'h00);
    bus_if.ss_n_i = 1'b1;
    bus_if.sck_i  = 1'b0;
    bus_if.mosi_i = 1'b0;
    tx_q.delete();
    rx_q.delete();
    {m_spif, m_wcol, m_undr, m_rovr} = 4'b0000;
    {m_spie, m_spe, m_cpol, m_cpha} = 4'b0000;
    m_spcr = 8'h00;
    tick(3);
    rst = 1'b0;
    tick(2);
    rd_chk("post_rst_spsr", ADR_SPSR);
    rd_chk("post_rst_spcr", ADR_SPCR);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
